// File: rtl/run_network_mc_if.sv
// Host-side bus of the run controller: request, abort, pixels and result.
// master: requester drives start/abort/pixels; slave: controller reports status.
interface run_network_mc_if #(
  parameter int HEIGHT  = 7,
  parameter int CLASSES = 2
);
  localparam int CW = $clog2(CLASSES);

  logic              start;
  logic              abort;
  logic [HEIGHT-1:0] pixels;
  logic              busy;
  logic              done;
  logic              result_valid;
  logic [CW-1:0]     result_class;
  logic              result_known;

  modport master (
    output start, abort, pixels,
    input  busy, done, result_valid, result_class, result_known
  );

  modport slave (
    input  start, abort, pixels,
    output busy, done, result_valid, result_class, result_known
  );
endinterface

// File: rtl/run_network_mc.sv
// Run controller for CLASSES parallel spiking networks sharing one pixel vector.
// Ports: clk, rst_n (sync, active low), host (slave bus), class_spike, pixels_q, net_rst, net_en.
module run_network_mc #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 7,
  parameter int CLASSES    = 2,
  parameter int RUN_CYCLES = HEIGHT * (2 ** (WIDTH + 2)),
  parameter int EARLY_LEAD = 0,
  parameter int CNT_W      = $clog2(RUN_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  run_network_mc_if.slave    host,
  input  logic [CLASSES-1:0] class_spike,
  output logic [HEIGHT-1:0]  pixels_q,
  output logic               net_rst,
  output logic               net_en
);

  localparam int CW = $clog2(CLASSES);
  localparam int IW = $clog2(RUN_CYCLES + 1);
  localparam logic [31:0] LEAD = 32'(EARLY_LEAD);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [IW-1:0] LAST = IW'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DECIDE
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] top;
    logic [CNT_W-1:0] second;
    logic [CW-1:0]    idx;
  } rank_t;

  state_t state;
  state_t state_n;

  logic [CNT_W-1:0] cnt   [CLASSES];
  logic [CNT_W-1:0] cnt_n [CLASSES];
  logic [IW-1:0]    iter;

  logic [CNT_W-1:0] lead_n;
  logic             stop_early;
  logic             last;
  logic             accept;
  rank_t            rd;
  logic             known;

  // Leader value/index (lowest index on ties) and the best of the rest.
  // A tie for first makes second equal to top.
  function automatic rank_t rank(input logic [CNT_W-1:0] v [CLASSES]);
    rank_t r;
    r.top    = v[0];
    r.second = '0;
    r.idx    = '0;
    for (int c = 1; c < CLASSES; c++) begin
      if (v[c] > r.top) begin
        r.second = r.top;
        r.top    = v[c];
        r.idx    = CW'(c);
      end else if (v[c] > r.second) begin
        r.second = v[c];
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] lead_of(
    input logic [CNT_W-1:0] v [CLASSES]
  );
    rank_t r;
    r = rank(v);
    return r.top - r.second;
  endfunction

  always_comb begin
    for (int c = 0; c < CLASSES; c++) begin
      cnt_n[c] = cnt[c];
      if (class_spike[c] && cnt[c] != CMAX) begin
        cnt_n[c] = cnt[c] + CNT_W'(1);
      end
    end
  end

  // Early stop looks at counts including this cycle's spikes.
  assign lead_n     = lead_of(cnt_n);
  assign stop_early = (EARLY_LEAD != 0) && (32'(lead_n) >= LEAD);
  assign last       = (iter == LAST);
  assign accept     = (state == IDLE) && host.start && !host.abort;

  assign rd    = rank(cnt);
  assign known = (rd.top != '0) && (rd.top != rd.second);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = CLEAR;
      end
      CLEAR: begin
        state_n = host.abort ? IDLE : RUN;
      end
      RUN: begin
        if (host.abort) begin
          state_n = IDLE;
        end else if (last || stop_early) begin
          state_n = DECIDE;
        end
      end
      DECIDE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixels_q          <= '0;
      net_rst           <= 1'b0;
      net_en            <= 1'b0;
      host.busy         <= 1'b0;
      host.done         <= 1'b0;
      host.result_valid <= 1'b0;
      host.result_class <= '0;
      host.result_known <= 1'b0;
      iter              <= '0;
      for (int c = 0; c < CLASSES; c++) cnt[c] <= '0;
    end else begin
      net_rst   <= (state_n == CLEAR);
      net_en    <= (state_n == RUN);
      host.busy <= (state_n != IDLE);
      host.done <= 1'b0;
      if (accept) begin
        pixels_q          <= host.pixels;
        host.result_valid <= 1'b0;
        iter              <= '0;
        for (int c = 0; c < CLASSES; c++) cnt[c] <= '0;
      end
      if (state == RUN) begin
        iter <= iter + IW'(1);
        for (int c = 0; c < CLASSES; c++) cnt[c] <= cnt_n[c];
      end
      if (state == DECIDE && !host.abort) begin
        host.done         <= 1'b1;
        host.result_valid <= 1'b1;
        host.result_known <= known;
        host.result_class <= known ? rd.idx : '0;
      end
    end
  end

endmodule

// File: tb/tb_run_network_mc.sv
// Bench for run_network_mc: two configurations driven with shared stimulus.
// A: 2 classes, no early stop; B: 4 classes, early lead 4; both 16 run cycles.
module tb_run_network_mc;

  localparam int H  = 7;
  localparam int RC = 16;
  localparam int NE = 22;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [H-1:0] pix = '0;
  logic [3:0]   spk = '0;

  logic [H-1:0] pq_a, pq_b;
  logic         nr_a, ne_a, nr_b, ne_b;

  int ncmp = 0;
  int nfail = 0;

  logic [3:0] sp [24];

  run_network_mc_if #(.HEIGHT(H), .CLASSES(2)) ha ();
  run_network_mc_if #(.HEIGHT(H), .CLASSES(4)) hb ();

  assign ha.start  = start;
  assign ha.abort  = abort;
  assign ha.pixels = pix;
  assign hb.start  = start;
  assign hb.abort  = abort;
  assign hb.pixels = pix;

  run_network_mc #(
    .HEIGHT(H), .CLASSES(2), .RUN_CYCLES(RC), .EARLY_LEAD(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .host(ha), .class_spike(spk[1:0]),
    .pixels_q(pq_a), .net_rst(nr_a), .net_en(ne_a)
  );

  run_network_mc #(
    .HEIGHT(H), .CLASSES(4), .RUN_CYCLES(RC), .EARLY_LEAD(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .host(hb), .class_spike(spk),
    .pixels_q(pq_b), .net_rst(nr_b), .net_en(ne_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: replay the spikes a run would see (sp[2..]) as counts,
  // stop when the lead condition holds, then pick the winner.
  task automatic model(input int nc, input int lead, output int n,
                       output int cls, output int known);
    int cnt[4];
    int top, nt, sec;
    bit stop;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    n = RC;
    stop = 0;
    for (int k = 0; k < RC && !stop; k++) begin
      for (int c = 0; c < nc; c++) cnt[c] += int'(sp[k + 2][c]);
      if (lead != 0) begin
        top = 0;
        for (int c = 0; c < nc; c++) if (cnt[c] > top) top = cnt[c];
        nt = 0;
        sec = 0;
        for (int c = 0; c < nc; c++) begin
          if (cnt[c] == top) nt++;
          else if (cnt[c] > sec) sec = cnt[c];
        end
        if (nt > 1) sec = top;
        if (top - sec >= lead) begin
          n = k + 1;
          stop = 1;
        end
      end
    end
    top = 0;
    for (int c = 0; c < nc; c++) if (cnt[c] > top) top = cnt[c];
    nt = 0;
    for (int c = 0; c < nc; c++) if (cnt[c] == top) nt++;
    known = (nt == 1 && top > 0) ? 1 : 0;
    cls = 0;
    if (known == 1) begin
      for (int c = nc - 1; c >= 0; c--) if (cnt[c] == top) cls = c;
    end
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_busy_a"}, ha.busy, 0);
    chk({name, "_busy_b"}, hb.busy, 0);
    chk({name, "_done_a"}, ha.done, 0);
    chk({name, "_done_b"}, hb.done, 0);
    chk({name, "_en_a"}, ne_a, 0);
    chk({name, "_en_b"}, ne_b, 0);
    chk({name, "_nrst_a"}, nr_a, 0);
    chk({name, "_nrst_b"}, nr_b, 0);
    chk({name, "_valid_a"}, ha.result_valid, 0);
    chk({name, "_valid_b"}, hb.result_valid, 0);
    chk({name, "_pq_a"}, pq_a, 0);
    chk({name, "_pq_b"}, pq_b, 0);
    chk({name, "_cls_a"}, ha.result_class, 0);
    chk({name, "_cls_b"}, hb.result_class, 0);
    chk({name, "_known_a"}, ha.result_known, 0);
    chk({name, "_known_b"}, hb.result_known, 0);
  endtask

  // Called on a negedge. rnd=0 drives pat every cycle; otherwise each class
  // fires with its own random probability for this run.
  task automatic run_case(input string name, input bit rnd,
                          input logic [3:0] pat, input int restart_at,
                          input int abort_at, input int rst_at);
    int w[4];
    int na, ca, ka, nb, cb, kb;
    logic [H-1:0] p;
    bit kill;
    bit ok;
    for (int c = 0; c < 4; c++) w[c] = $urandom_range(0, 100);
    for (int e = 0; e < 24; e++) begin
      for (int c = 0; c < 4; c++) begin
        sp[e][c] = rnd ? ($urandom_range(0, 99) < w[c]) : pat[c];
      end
    end
    model(2, 0, na, ca, ka);
    model(4, 4, nb, cb, kb);
    p = H'($urandom);
    pix = p;
    spk = sp[0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pix = ~p;
    chk({name, "_e0_busy_a"}, ha.busy, 1);
    chk({name, "_e0_busy_b"}, hb.busy, 1);
    chk({name, "_e0_nrst_a"}, nr_a, 1);
    chk({name, "_e0_nrst_b"}, nr_b, 1);
    chk({name, "_e0_en_a"}, ne_a, 0);
    chk({name, "_e0_en_b"}, ne_b, 0);
    chk({name, "_e0_pq_a"}, pq_a, p);
    chk({name, "_e0_valid_a"}, ha.result_valid, 0);
    for (int e = 1; e <= NE; e++) begin
      spk = sp[e];
      start = (e == restart_at);
      abort = (e == abort_at);
      rst_n = !(e == rst_at);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      kill = (abort_at > 0 && e >= abort_at) || (rst_at > 0 && e >= rst_at);
      chk($sformatf("%s_busy_a_e%0d", name, e), ha.busy,
          32'(!kill && e <= na + 1));
      chk($sformatf("%s_busy_b_e%0d", name, e), hb.busy,
          32'(!kill && e <= nb + 1));
      chk($sformatf("%s_en_a_e%0d", name, e), ne_a, 32'(!kill && e <= na));
      chk($sformatf("%s_en_b_e%0d", name, e), ne_b, 32'(!kill && e <= nb));
      chk($sformatf("%s_done_a_e%0d", name, e), ha.done,
          32'(!kill && e == na + 2));
      chk($sformatf("%s_done_b_e%0d", name, e), hb.done,
          32'(!kill && e == nb + 2));
      chk($sformatf("%s_nrst_a_e%0d", name, e), nr_a, 0);
      chk($sformatf("%s_nrst_b_e%0d", name, e), nr_b, 0);
    end
    ok = (abort_at == 0 && rst_at == 0);
    chk({name, "_valid_a"}, ha.result_valid, 32'(ok));
    chk({name, "_valid_b"}, hb.result_valid, 32'(ok));
    chk({name, "_pq_a"}, pq_a, (rst_at > 0) ? 32'(0) : 32'(p));
    chk({name, "_pq_b"}, pq_b, (rst_at > 0) ? 32'(0) : 32'(p));
    if (ok) begin
      chk({name, "_cls_a"}, ha.result_class, ca);
      chk({name, "_cls_b"}, hb.result_class, cb);
      chk({name, "_known_a"}, ha.result_known, ka);
      chk({name, "_known_b"}, hb.result_known, kb);
    end else if (rst_at > 0) begin
      check_reset_state({name, "_post_rst"});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("idle_start_abort_busy_a", ha.busy, 0);
    chk("idle_start_abort_nrst_b", nr_b, 0);

    run_case("t1", 1'b0, 4'b0001, 0, 0, 0);
    chk("t1_fixed_cls_a", ha.result_class, 0);
    chk("t1_fixed_known_a", ha.result_known, 1);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("hold_busy_a", ha.busy, 0);
    chk("hold_valid_a", ha.result_valid, 1);
    chk("hold_known_a", ha.result_known, 1);

    run_case("t2_tie", 1'b0, 4'b0011, 0, 0, 0);
    run_case("t3_zero_restart", 1'b0, 4'b0000, 5, 0, 0);
    run_case("t4_abort", 1'b0, 4'b0000, 0, 7, 0);
    run_case("t4_after", 1'b0, 4'b0001, 0, 0, 0);
    run_case("t5_early", 1'b0, 4'b0100, 0, 0, 0);
    chk("t5_fixed_cls_b", hb.result_class, 2);
    run_case("t6_reset", 1'b0, 4'b0001, 0, 0, 8);
    run_case("t6_after", 1'b0, 4'b0001, 0, 0, 0);

    for (int r = 0; r < 24; r++) begin
      run_case($sformatf("rnd%0d", r), 1'b1, 4'b0000, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
